// File: rtl/forward_kinematics_if.sv
// Bundle of the start request, operand, and result signals of the two-link forward-kinematics engine.
// The master drives the request and operands. The slave (the engine) returns the results and the status.
interface forward_kinematics_if #(
  parameter int LEN_W  = 14,
  parameter int TRIG_W = 16
);
  logic              enable;
  logic [LEN_W-1:0]  l1;
  logic [LEN_W-1:0]  l2;
  logic [TRIG_W-1:0] cosTh1;
  logic [TRIG_W-1:0] sinTh1;
  logic [TRIG_W-1:0] cosTh12;
  logic [TRIG_W-1:0] sinTh12;
  logic [LEN_W-1:0]  xTarget;
  logic [LEN_W-1:0]  yTarget;
  logic              outOfRange;
  logic              busy;
  logic              dataReady;

  modport master (
    output enable, l1, l2, cosTh1, sinTh1, cosTh12, sinTh12,
    input  xTarget, yTarget, outOfRange, busy, dataReady
  );

  modport slave (
    input  enable, l1, l2, cosTh1, sinTh1, cosTh12, sinTh12,
    output xTarget, yTarget, outOfRange, busy, dataReady
  );
endinterface

// File: rtl/forward_kinematics.sv
// Two-link planar forward kinematics. One time-shared signed multiplier forms the four link/trig products over four cycles.
// The sums are clamped to the unsigned output range.
module forward_kinematics #(
  parameter int LEN_W  = 14,
  parameter int TRIG_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  forward_kinematics_if.slave   bus
);
  localparam int FRAC   = 14;
  localparam int PROD_W = LEN_W + 1 + TRIG_W;
  localparam int ACC_W  = LEN_W + 3;

  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX    = ACC_W'((1 << LEN_W) - 1);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, SAT} state_e;

  state_e                    state_q;
  logic [LEN_W-1:0]          l1_q, l2_q;
  logic [TRIG_W-1:0]         cos1_q, sin1_q, cos12_q, sin12_q;
  logic signed [ACC_W-1:0]   acc_x_q, acc_y_q;
  logic [LEN_W-1:0]          x_q, y_q;
  logic                      oor_q, busy_q, ready_q;

  // Operand select for the single shared multiplier.
  logic [LEN_W-1:0]          len_sel;
  logic [TRIG_W-1:0]         trig_sel;
  logic signed [LEN_W:0]     mul_a;
  logic signed [TRIG_W-1:0]  mul_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  prod_rnd;
  logic signed [ACC_W-1:0]   term;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    len_sel  = l1_q;
    trig_sel = cos1_q;
    unique case (state_q)
      MUL1:    begin len_sel = l2_q; trig_sel = cos12_q; end
      MUL2:    begin len_sel = l1_q; trig_sel = sin1_q;  end
      MUL3:    begin len_sel = l2_q; trig_sel = sin12_q; end
      default: begin len_sel = l1_q; trig_sel = cos1_q;  end
    endcase
  end

  assign mul_a    = $signed({1'b0, len_sel});
  assign mul_b    = $signed(trig_sel);
  assign prod     = mul_a * mul_b;
  // Round half-up: the arithmetic shift floors, so adding half an LSB first gives round-half-up.
  assign prod_rnd = (prod + ROUND_BIAS) >>> FRAC;
  assign term     = ACC_W'(prod_rnd);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      l1_q    <= '0;
      l2_q    <= '0;
      cos1_q  <= '0;
      sin1_q  <= '0;
      cos12_q <= '0;
      sin12_q <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      oor_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.enable) begin
          l1_q    <= bus.l1;
          l2_q    <= bus.l2;
          cos1_q  <= bus.cosTh1;
          sin1_q  <= bus.sinTh1;
          cos12_q <= bus.cosTh12;
          sin12_q <= bus.sinTh12;
          acc_x_q <= '0;
          acc_y_q <= '0;
          busy_q  <= 1'b1;
          state_q <= MUL0;
        end
        MUL0: begin acc_x_q <= acc_x_q + term; state_q <= MUL1; end
        MUL1: begin acc_x_q <= acc_x_q + term; state_q <= MUL2; end
        MUL2: begin acc_y_q <= acc_y_q + term; state_q <= MUL3; end
        MUL3: begin acc_y_q <= acc_y_q + term; state_q <= SAT;  end
        SAT: begin
          x_q     <= (acc_x_q < 0) ? '0 : (acc_x_q > SAT_MAX) ? LEN_W'(SAT_MAX) : LEN_W'(acc_x_q);
          y_q     <= (acc_y_q < 0) ? '0 : (acc_y_q > SAT_MAX) ? LEN_W'(SAT_MAX) : LEN_W'(acc_y_q);
          oor_q   <= (acc_x_q < 0) || (acc_x_q > SAT_MAX) || (acc_y_q < 0) || (acc_y_q > SAT_MAX);
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.xTarget    = x_q;
  assign bus.yTarget    = y_q;
  assign bus.outOfRange = oor_q;
  assign bus.busy       = busy_q;
  assign bus.dataReady  = ready_q;
endmodule

// File: tb/tb_forward_kinematics.sv
// Directed bench for forward_kinematics: hand-computed vectors, latency, rounding, saturation, reset abort, and throughput.
module tb_forward_kinematics;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  forward_kinematics_if #(.LEN_W(14), .TRIG_W(16)) fk_bus ();
  forward_kinematics #(.LEN_W(14), .TRIG_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fk_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands and pulse enable through one edge. Return 1 ns after the capture edge.
  task automatic start(input int a, input int b, input int c1, input int s1,
                       input int c12, input int s12);
    fk_bus.l1      = 14'(a);
    fk_bus.l2      = 14'(b);
    fk_bus.cosTh1  = 16'(c1);
    fk_bus.sinTh1  = 16'(s1);
    fk_bus.cosTh12 = 16'(c12);
    fk_bus.sinTh12 = 16'(s12);
    fk_bus.enable  = 1'b1;
    step();
    fk_bus.enable  = 1'b0;
  endtask

  // Count edges until dataReady is seen. Return -1 if it does not arrive within the bound.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (fk_bus.dataReady === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input int a, input int b, input int c1, input int s1,
                     input int c12, input int s12, input int ex, input int ey, input int eo);
    int lat;
    start(a, b, c1, s1, c12, s12);
    wait_ready(lat);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_x"}, int'(fk_bus.xTarget), ex);
    check({tag, "_y"}, int'(fk_bus.yTarget), ey);
    check({tag, "_oor"}, int'(fk_bus.outOfRange), eo);
    step();
  endtask

  initial begin
    int pulses;
    int last_cyc;
    int px;
    fk_bus.enable = 1'b0;
    fk_bus.l1 = '0; fk_bus.l2 = '0;
    fk_bus.cosTh1 = '0; fk_bus.sinTh1 = '0; fk_bus.cosTh12 = '0; fk_bus.sinTh12 = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    check("rst_x", int'(fk_bus.xTarget), 0);
    check("rst_y", int'(fk_bus.yTarget), 0);
    check("rst_oor", int'(fk_bus.outOfRange), 0);
    check("rst_busy", int'(fk_bus.busy), 0);
    check("rst_ready", int'(fk_bus.dataReady), 0);

    // Both links along +x.
    start(4000, 4000, 16384, 0, 16384, 0);
    check("busy_after_capture", int'(fk_bus.busy), 1);
    wait_ready(px);
    check("cos_latency", px, 5);
    check("cos_x", int'(fk_bus.xTarget), 8000);
    check("cos_y", int'(fk_bus.yTarget), 0);
    check("cos_oor", int'(fk_bus.outOfRange), 0);
    check("cos_busy_at_ready", int'(fk_bus.busy), 0);
    step();
    check("ready_single_pulse", int'(fk_bus.dataReady), 0);
    step(); step();
    check("hold_x", int'(fk_bus.xTarget), 8000);

    run("sin",   4000, 4000, 0, 16384, 0, 16384, 0, 8000, 0);
    run("neg",   4000, 4000, -16384, 0, -16384, 0, 0, 0, 1);
    run("ovf",   16383, 16383, 16384, 0, 16384, 0, 16383, 0, 1);
    run("rnd_up", 1, 0, 8192, 0, 0, 0, 1, 0, 0);
    run("rnd_dn", 1, 0, 8191, 0, 0, 0, 0, 0, 0);
    run("mixed", 1000, 2000, 8192, 16384, 4096, -4096, 1000, 500, 0);

    // Reset at edge k+2 aborts the computation.
    start(4000, 4000, 16384, 0, 16384, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (fk_bus.dataReady === 1'b1) pulses++;
      step();
    end
    check("abort_no_ready", pulses, 0);
    check("abort_x", int'(fk_bus.xTarget), 8000 - 8000);
    check("abort_oor", int'(fk_bus.outOfRange), 0);
    check("abort_busy", int'(fk_bus.busy), 0);

    // Inputs changed after capture and enable during MUL1 are both ignored.
    start(100, 100, 16384, 0, 16384, 0);
    fk_bus.l1 = 14'd5000;
    fk_bus.cosTh1 = 16'(-16384);
    step();
    fk_bus.enable = 1'b1;
    step();
    fk_bus.enable = 1'b0;
    pulses = 0;
    px = -1;
    for (int n = 0; n < 15; n++) begin
      if (fk_bus.dataReady === 1'b1) begin
        pulses++;
        px = int'(fk_bus.xTarget);
      end
      step();
    end
    check("busy_enable_pulses", pulses, 1);
    check("inflight_x", px, 200);

    // Continuous enable gives one result every 6 cycles.
    fk_bus.l1 = 14'd1000; fk_bus.l2 = 14'd2000;
    fk_bus.cosTh1 = 16'd8192; fk_bus.sinTh1 = 16'd16384;
    fk_bus.cosTh12 = 16'd4096; fk_bus.sinTh12 = 16'(-4096);
    fk_bus.enable = 1'b1;
    pulses = 0;
    last_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (fk_bus.dataReady === 1'b1) begin
        if (last_cyc >= 0) check("stream_interval", n - last_cyc, 6);
        check("stream_x", int'(fk_bus.xTarget), 1000);
        check("stream_y", int'(fk_bus.yTarget), 500);
        last_cyc = n;
        pulses++;
      end
    end
    fk_bus.enable = 1'b0;
    check("stream_pulses", pulses, 6);
    for (int n = 0; n < 8; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
